// File: rtl/hazard_pkg.sv
// Shared opcodes, FSM state type and register-usage decode for the pipeline
// hazard controller.
package hazard_pkg;

   localparam int unsigned OP_W  = 4;
   localparam int unsigned REG_W = 4;

   localparam logic [OP_W-1:0] ADD = 4'b0000;
   localparam logic [OP_W-1:0] LW  = 4'b1000;
   localparam logic [OP_W-1:0] SW  = 4'b1001;
   localparam logic [OP_W-1:0] B   = 4'b1100;
   localparam logic [OP_W-1:0] BR  = 4'b1101;
   localparam logic [OP_W-1:0] HLT = 4'b1111;

   typedef enum logic [2:0] {
      RUN    = 3'd0,
      DWAIT  = 3'd1,
      IWAIT  = 3'd2,
      DRAIN  = 3'd3,
      HALTED = 3'd4
   } state_e;

   // Every op except HLT uses rs (ALU operand, load/store base, branch operand).
   function automatic logic reads_rs(input logic [OP_W-1:0] op);
      return (op != HLT);
   endfunction

   // rt is read by ALU ops (0xxx), SW (store data) and B (compare); BR jumps via rs only.
   function automatic logic reads_rt(input logic [OP_W-1:0] op);
      return (op[OP_W-1] == 1'b0) || (op == SW) || (op == B);
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the instruction in ID and a
// load in EX; store data matched only on rt is forwarded later and never stalls.
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [OP_W-1:0]  ifid_op,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic [OP_W-1:0]  idex_op,
   input  logic [REG_W-1:0] idex_rd,
   output logic             load_use_c
);

   logic rs_hit;
   logic rt_hit;

   always_comb begin
      rs_hit     = reads_rs(ifid_op) && (ifid_rs == idex_rd);
      rt_hit     = reads_rt(ifid_op) && (ifid_rt == idex_rd) && (ifid_op != SW);
      load_use_c = (idex_op == LW) && (idex_rd != '0) && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, I/D miss freezes, branch
// flush, HLT drain, and a saturating stall-cycle counter.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  ifid_op,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic [OP_W-1:0]  idex_op,
   input  logic [REG_W-1:0] idex_rd,
   input  logic             branch_taken,
   input  logic             imem_miss,
   input  logic             dmem_miss,
   input  logic             mem_fill_done,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic             imem_cancel,
   output logic             halted,
   output logic [CNT_W-1:0] perf_stall_cnt
);

   localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

   state_e             state_q, state_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic               dhold_q, dhold_d;
   logic [CNT_W-1:0]   perf_q, perf_d;
   logic               load_use_c;

   load_use_detect u_load_use_detect (
      .ifid_op    (ifid_op),
      .ifid_rs    (ifid_rs),
      .ifid_rt    (ifid_rt),
      .idex_op    (idex_op),
      .idex_rd    (idex_rd),
      .load_use_c (load_use_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         drain_q <= '0;
         dhold_q <= 1'b0;
         perf_q  <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         dhold_q <= dhold_d;
         perf_q  <= perf_d;
      end
   end

   // Next state and same-cycle pipeline controls.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      dhold_d     = dhold_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_write = 1'b1;
      memwb_write = 1'b1;
      imem_cancel = 1'b0;
      halted      = 1'b0;

      case (state_q)
         RUN: begin
            if (dmem_miss) begin
               {pc_write, ifid_write, exmem_write, memwb_write} = 4'b0000;
               state_d = DWAIT;
            end else if (load_use_c) begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               idex_flush = 1'b1;
            end else if (branch_taken) begin
               ifid_flush  = 1'b1;
               imem_cancel = imem_miss;
            end else if (imem_miss) begin
               pc_write   = 1'b0;
               ifid_flush = 1'b1;
               state_d    = IWAIT;
            end else if (ifid_op == HLT) begin
               pc_write   = 1'b0;
               ifid_flush = 1'b1;
               drain_d    = DRAIN_W'(DRAIN_CYC);
               state_d    = DRAIN;
            end
         end
         DWAIT: begin
            {pc_write, ifid_write, exmem_write, memwb_write} = 4'b0000;
            if (mem_fill_done) state_d = RUN;
         end
         IWAIT: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            if (mem_fill_done) state_d = RUN;
         end
         DRAIN: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            // A data miss freezes everything and pauses the drain count through the fill cycle.
            if (dhold_q || dmem_miss) begin
               {pc_write, ifid_write, exmem_write, memwb_write} = 4'b0000;
               ifid_flush = 1'b0;
               if (dhold_q) dhold_d = !mem_fill_done;
               else         dhold_d = 1'b1;
            end else if (drain_q > DRAIN_W'(1)) begin
               drain_d = drain_q - DRAIN_W'(1);
            end else begin
               drain_d = '0;
               state_d = HALTED;
            end
         end
         HALTED: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            halted     = 1'b1;
         end
         default: state_d = RUN;
      endcase

      if (rst) begin
         {pc_write, ifid_write, exmem_write, memwb_write} = 4'b0000;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         imem_cancel = 1'b0;
         halted      = 1'b0;
      end
   end

   // Count non-advancing cycles outside HALTED, saturating at all-ones.
   always_comb begin
      perf_d = perf_q;
      if (!pc_write && (state_q != HALTED) && (perf_q != {CNT_W{1'b1}}))
         perf_d = perf_q + CNT_W'(1);
   end

   assign perf_stall_cnt = perf_q;

endmodule
